// File: rtl/memory_arbiter.sv
// Two-port (instruction fetch A, data B) arbiter in front of a single 256-word memory block.
// Define ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise port A wins every tie.
module memory_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 aReq,
    input  logic                 aWrite,
    input  logic [7:0]           aAddr,
    input  logic [2*WIDTH-1:0]   aWData,
    output logic [2*WIDTH-1:0]   aRData,
    output logic                 aAck,
    input  logic                 bReq,
    input  logic                 bWrite,
    input  logic [7:0]           bAddr,
    input  logic [2*WIDTH-1:0]   bWData,
    output logic [2*WIDTH-1:0]   bRData,
    output logic                 bAck,
    output logic                 grantB,
    output logic                 busy,
    output logic                 memoryWrite,
    output logic                 memoryRead,
    output logic [7:0]           memoryAddress,
    output logic [2*WIDTH-1:0]   memoryWriteData,
    input  logic [2*WIDTH-1:0]   memoryOutData
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

    state_t               state, state_nxt;
    logic                 cmd_write;
    logic [7:0]           cmd_addr;
    logic [2*WIDTH-1:0]   cmd_wdata;
    logic                 grant_b;
    logic                 pick_b;
    logic                 any_req;

    assign any_req = aReq | bReq;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_b;

    // On a tie, hand the memory to whichever port lost the previous grant.
    always_comb pick_b = bReq & (~aReq | ~last_grant_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_b <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_grant_b <= pick_b;
        end
    end
`else
    always_comb pick_b = bReq & ~aReq;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Winner's command is frozen for the whole transaction so A/B may change freely afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_b   <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (state == IDLE && any_req) begin
            grant_b   <= pick_b;
            cmd_write <= pick_b ? bWrite : aWrite;
            cmd_addr  <= pick_b ? bAddr  : aAddr;
            cmd_wdata <= pick_b ? bWData : aWData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aRData <= '0;
            bRData <= '0;
        end else if (state == CAPTURE && !cmd_write) begin
            if (grant_b) begin
                bRData <= memoryOutData;
            end else begin
                aRData <= memoryOutData;
            end
        end
    end

    assign grantB          = grant_b;
    assign busy            = (state != IDLE);
    assign memoryWrite     = (state == ISSUE) &  cmd_write;
    assign memoryRead      = (state == ISSUE) & ~cmd_write;
    assign memoryAddress   = cmd_addr;
    assign memoryWriteData = cmd_wdata;
    assign aAck            = (state == ACK) & ~grant_b;
    assign bAck            = (state == ACK) &  grant_b;

endmodule
